// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master port.
package spi_pkg;

  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;
  localparam int SPI_FRAME_W = 16;
  localparam int SPI_BIT_W   = 5;

  localparam logic SPI_RW_READ = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_TRAIL
  } spi_state_e;

  // Reads send a zero data byte so the slave's reply never collides with stale write data.
  function automatic logic [SPI_FRAME_W-1:0] spi_build_frame(
    input logic [SPI_ADDR_W-1:0] addr,
    input logic                  rw,
    input logic [SPI_DATA_W-1:0] wdata
  );
    return {addr, rw, (rw == SPI_RW_READ) ? {SPI_DATA_W{1'b0}} : wdata};
  endfunction

endpackage

// File: rtl/spi_half_timer.sv
// Half-period timer: pulses tick every CLKDIV clk cycles while run is high.
module spi_half_timer #(
  parameter int CLKDIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = $clog2(CLKDIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKDIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_port.sv
// SPI mode-0 master issuing one 16-bit {addr,rw,data} frame per accepted command.
// Optional build macro SPIM_MISO_SYNC_EN: two-flop miso synchronizer, sample at sclk fall.
module spi_master_port
  import spi_pkg::*;
#(
  parameter int CLKDIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  rw,
  input  logic [SPI_ADDR_W-1:0] addr,
  input  logic [SPI_DATA_W-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [SPI_DATA_W-1:0] rdata,
  output logic                  sclk_pin,
  output logic                  cs_pin,
  output logic                  mosi_pin,
  input  logic                  miso_pin
);

  spi_state_e             state_q, state_d;
  logic [SPI_FRAME_W-1:0] tx_q, tx_d;
  logic [SPI_FRAME_W-1:0] rx_q, rx_d;
  logic [SPI_BIT_W-1:0]   bit_q, bit_d;
  logic                   sclk_q, sclk_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rw_q, rw_d;
  logic [SPI_DATA_W-1:0]  rdata_q, rdata_d;
  logic                   tick;
  logic                   miso_smp;

`ifdef SPIM_MISO_SYNC_EN
  // The synchronizer eats two cycles of the high half, so shorter halves cannot work.
  if (CLKDIV < 3) begin : g_bad_clkdiv
    $fatal(1, "spi_master_port: CLKDIV must be >= 3 with SPIM_MISO_SYNC_EN");
  end

  logic miso_s1_q, miso_s2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= miso_pin;
      miso_s2_q <= miso_s1_q;
    end
  end

  assign miso_smp = miso_s2_q;
`else
  assign miso_smp = miso_pin;
`endif

  spi_half_timer #(
    .CLKDIV(CLKDIV)
  ) u_half_timer (
    .clk  (clk),
    .reset(reset),
    .run  (state_q != ST_IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rw_d    = rw_q;
    rdata_d = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = 1'b0;
        if (start) begin
          tx_d    = spi_build_frame(addr, rw, wdata);
          rw_d    = rw;
          bit_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
`ifndef SPIM_MISO_SYNC_EN
            rx_d = {rx_q[SPI_FRAME_W-2:0], miso_smp};
`endif
          end else begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[SPI_FRAME_W-2:0], 1'b0};
`ifdef SPIM_MISO_SYNC_EN
            rx_d = {rx_q[SPI_FRAME_W-2:0], miso_smp};
`endif
            if (bit_q == SPI_BIT_W'(SPI_FRAME_W - 1)) begin
              bit_d   = '0;
              state_d = ST_TRAIL;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end

      ST_TRAIL: begin
        if (tick) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (rw_q == SPI_RW_READ) begin
            rdata_d = rx_q[SPI_DATA_W-1:0];
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign sclk_pin = sclk_q;
  assign cs_pin   = (state_q == ST_IDLE);
  assign mosi_pin = (state_q == ST_SHIFT) && tx_q[SPI_FRAME_W-1];

endmodule

// File: tb/tb_spi_master_port.sv
// Scoreboard bench for spi_master_port: a main instance with a slave model plus a fast-divider instance.
module tb_spi_master_port;

`ifdef SPIM_MISO_SYNC_EN
  localparam int CA = 3;
  localparam int CB = 3;
`else
  localparam int CA = 2;
  localparam int CB = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         cyc = 0;

  logic       start_a = 1'b0, rw_a = 1'b0;
  logic [6:0] addr_a = '0;
  logic [7:0] wdata_a = '0;
  logic       busy_a, done_a, sclk_a, cs_a, mosi_a;
  logic [7:0] rdata_a;
  logic       miso_a = 1'b0;

  logic       start_b = 1'b0, rw_b = 1'b0;
  logic [6:0] addr_b = '0;
  logic [7:0] wdata_b = '0;
  logic       busy_b, done_b, sclk_b, cs_b, mosi_b;
  logic [7:0] rdata_b;
  logic       miso_b = 1'b0;

  spi_master_port #(.CLKDIV(CA)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rw(rw_a), .addr(addr_a), .wdata(wdata_a),
    .busy(busy_a), .done(done_a), .rdata(rdata_a), .sclk_pin(sclk_a), .cs_pin(cs_a),
    .mosi_pin(mosi_a), .miso_pin(miso_a)
  );

  spi_master_port #(.CLKDIV(CB)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rw(rw_b), .addr(addr_b), .wdata(wdata_b),
    .busy(busy_b), .done(done_b), .rdata(rdata_b), .sclk_pin(sclk_b), .cs_pin(cs_b),
    .mosi_pin(mosi_b), .miso_pin(miso_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] mosi;
    logic [7:0]  rdata;
    int          done_cyc;
  } exp_t;

  exp_t        sb[$];
  int          gaps[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          frames_a = 0;
  int          frames_b = 0;
  int          bad_idle = 0;
  int          bad_busy = 0;
  bit          b2b = 1'b0;
  logic [7:0]  rdata_model = '0;
  logic [15:0] sl_word = '0;
  int          exp_b_done = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one command on instance A and record what it must produce.
  task automatic push_a(input logic r, input logic [6:0] a, input logic [7:0] w,
                        input logic [7:0] rb);
    exp_t e;
    rw_a    = r;
    addr_a  = a;
    wdata_a = w;
    start_a = 1'b1;
    sl_word = {8'h3C, rb};
    e.mosi  = {a, r, r ? 8'h00 : w};
    if (r) rdata_model = rb;
    e.rdata    = rdata_model;
    e.done_cyc = cyc + 1 + 33 * CA;
    sb.push_back(e);
  endtask

  task automatic wait_done(input bit use_b, input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      seen = use_b ? done_b : done_a;
    end
    if (!seen) check(use_b ? "done_timeout_b" : "done_timeout_a", 32'd0, 32'd1);
  endtask

  // Pin monitors and slave model, all evaluated mid-cycle.
  initial begin
    logic        cs_prev = 1'b1, sclk_prev = 1'b0;
    logic        cs_prev_b = 1'b1, sclk_prev_b = 1'b0;
    logic [15:0] mosi_sh = '0, mosi_sh_b = '0;
    int          rises = 0, rises_b = 0, cs_low_cnt = 0, cs_hi_run = 0;
    int          sl_idx = 0;
    bit          sl_pend = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!cs_a && cs_prev) begin
        if (b2b) gaps.push_back(cs_hi_run);
        cs_hi_run  = 0;
        mosi_sh    = '0;
        rises      = 0;
        cs_low_cnt = 0;
      end
      if (!cs_a) begin
        cs_low_cnt++;
        if (sclk_a && !sclk_prev) begin
          mosi_sh = {mosi_sh[14:0], mosi_a};
          rises++;
        end
        if (!busy_a) bad_busy++;
      end else begin
        cs_hi_run++;
        if (sclk_a) bad_idle++;
      end
      if (done_a) begin
        if (sb.size() == 0) begin
          check("unexpected_done_a", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          frames_a++;
          check("mosi_frame", 32'(mosi_sh), 32'(e.mosi));
          check("sclk_rises", 32'(rises), 32'd16);
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("cs_low_len", 32'(cs_low_cnt), 32'(33 * CA));
          check("rdata", 32'(rdata_a), 32'(e.rdata));
          check("busy_at_done", 32'(busy_a), 32'd0);
        end
      end
      // Slave shifts its next bit out one clk after it sees sclk fall.
      if (cs_a) begin
        sl_idx  = 0;
        sl_pend = 1'b0;
      end else begin
        if (sl_pend) begin
          sl_idx++;
          sl_pend = 1'b0;
        end
        if (sclk_prev && !sclk_a) sl_pend = 1'b1;
      end
      miso_a    = (sl_idx < 16) ? sl_word[4'(15 - sl_idx)] : 1'b0;
      cs_prev   = cs_a;
      sclk_prev = sclk_a;

      if (!cs_b && cs_prev_b) begin
        mosi_sh_b = '0;
        rises_b   = 0;
      end
      if (!cs_b && sclk_b && !sclk_prev_b) begin
        mosi_sh_b = {mosi_sh_b[14:0], mosi_b};
        rises_b++;
      end
      if (cs_b && sclk_b) bad_idle++;
      if (done_b) begin
        frames_b++;
        check("b_mosi_frame", 32'(mosi_sh_b), 32'h0000_FEFF);
        check("b_sclk_rises", 32'(rises_b), 32'd16);
        check("b_done_cycle", 32'(cyc), 32'(exp_b_done));
      end
      cs_prev_b   = cs_b;
      sclk_prev_b = sclk_b;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs_a), 32'd1);
    check("rst_sclk", 32'(sclk_a), 32'd0);
    check("rst_mosi", 32'(mosi_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_rdata", 32'(rdata_a), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Abort a read around bit 5 with reset.
    rw_a    = 1'b1;
    addr_a  = 7'h15;
    sl_word = 16'hFFFF;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (11 * CA) @(negedge clk);
    check("mid_busy", 32'(busy_a), 32'd1);
    check("mid_cs", 32'(cs_a), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_cs", 32'(cs_a), 32'd1);
    check("abort_sclk", 32'(sclk_a), 32'd0);
    check("abort_mosi", 32'(mosi_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_rdata", 32'(rdata_a), 32'd0);
    repeat (40 * CA) @(negedge clk);

    push_a(1'b0, 7'h2A, 8'hC3, 8'h00);
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0, 40 * CA + 10);
    @(negedge clk);

    push_a(1'b1, 7'h2A, 8'h00, 8'hC3);
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0, 40 * CA + 10);
    @(negedge clk);

    push_a(1'b1, 7'h05, 8'h00, 8'hA5);
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0, 40 * CA + 10);
    @(negedge clk);

    push_a(1'b0, 7'h01, 8'h5A, 8'h00);
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0, 40 * CA + 10);
    @(negedge clk);

    // Starts while busy must be dropped.
    push_a(1'b0, 7'h11, 8'h22, 8'h00);
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    rw_a    = 1'b1;
    addr_a  = 7'h7E;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (10) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0, 40 * CA + 10);
    repeat (40 * CA) @(negedge clk);
    check("frames_after_ignore", 32'(frames_a), 32'd5);

    // start held high across three frames.
    b2b = 1'b1;
    push_a(1'b0, 7'h10, 8'h5A, 8'h00);
    wait_done(1'b0, 40 * CA + 10);
    push_a(1'b1, 7'h33, 8'h00, 8'h96);
    wait_done(1'b0, 40 * CA + 10);
    push_a(1'b0, 7'h7F, 8'h00, 8'h00);
    wait_done(1'b0, 40 * CA + 10);
    start_a = 1'b0;
    b2b     = 1'b0;
    repeat (40 * CA) @(negedge clk);
    check("frames_b2b", 32'(frames_a), 32'd8);
    check("b2b_gap_cnt", 32'(gaps.size()), 32'd3);
    check("b2b_gap1", 32'(gaps[1]), 32'd1);
    check("b2b_gap2", 32'(gaps[2]), 32'd1);

    rw_b       = 1'b0;
    addr_b     = 7'h7F;
    wdata_b    = 8'hFF;
    start_b    = 1'b1;
    exp_b_done = cyc + 1 + 33 * CB;
    @(negedge clk);
    start_b = 1'b0;
    wait_done(1'b1, 40 * CB + 10);
    repeat (5) @(negedge clk);
    check("frames_b", 32'(frames_b), 32'd1);
    check("b_rdata_hold", 32'(rdata_b), 32'd0);

    check("sclk_while_cs_high", 32'(bad_idle), 32'd0);
    check("busy_low_in_frame", 32'(bad_busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
